// File: rtl/ext_pkg.sv
// Shared types and helpers for the extended-sample accumulator.
// Sample widening is written width-generic so any instance size can reuse it.
package ext_pkg;

    localparam int R_DEF       = 25;
    localparam int COUNT_W_DEF = 8;
    localparam int MAX_W       = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Widen the low w bits of data to MAX_W bits: sign-extend when sgn=1, else zero-fill.
    function automatic logic [MAX_W-1:0] widen(input logic [MAX_W-1:0] data,
                                               input int unsigned     w,
                                               input logic            sgn);
        logic [MAX_W-1:0] low_mask;
        logic [MAX_W-1:0] top_bit;
        logic             fill;
        low_mask = (MAX_W'(1) << w) - MAX_W'(1);
        top_bit  = MAX_W'(1) << (w - 1);
        fill     = sgn & (|(data & top_bit));
        return (data & low_mask) | (fill ? ~low_mask : '0);
    endfunction

endpackage

// File: rtl/ext_accumulator.sv
// Sums a programmable number of R-bit extended samples into an ACC_W-bit block sum.
// valid/ready on both sides: a transfer happens on a clock edge where valid && ready.
module ext_accumulator
    import ext_pkg::*;
#(
    parameter int  R       = R_DEF,
    parameter int  COUNT_W = COUNT_W_DEF,
    localparam int ACC_W   = R + COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [R-1:0]       in_data,
    input  logic               in_signed,
    input  logic [COUNT_W-1:0] len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_signed
);

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] tgt;
    logic               mode;

    logic               accept;
    logic               fire;
    logic               start;
    logic [COUNT_W-1:0] tgt_in;
    logic [ACC_W-1:0]   first_wide;
    logic [ACC_W-1:0]   next_wide;

    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;
    // A sample accepted outside ACCUM always opens a new block (IDLE, or HOLD while firing).
    assign start  = accept && (state != ACCUM);
    assign tgt_in = (len == '0) ? COUNT_W'(1) : len;

    assign first_wide = ACC_W'(widen(MAX_W'(in_data), R, in_signed));
    assign next_wide  = ACC_W'(widen(MAX_W'(in_data), R, mode));

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b1;
        out_valid  = 1'b0;
        out_sum    = acc;
        out_signed = mode;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = (tgt_in == COUNT_W'(1)) ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (accept && (cnt + COUNT_W'(1) == tgt)) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (fire) begin
                    if (accept) state_nxt = (tgt_in == COUNT_W'(1)) ? HOLD : ACCUM;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            tgt   <= COUNT_W'(1);
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                tgt  <= tgt_in;
                mode <= in_signed;
                acc  <= first_wide;
                cnt  <= COUNT_W'(1);
            end else if (accept) begin
                // Modulo 2^ACC_W; the extra COUNT_W bits make overflow impossible.
                acc <= acc + next_wide;
                cnt <= cnt + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ext_accumulator.sv
// Directed bench for ext_accumulator: table of blocks plus hand-written multi-cycle sequences.
module tb_ext_accumulator;

    localparam int R       = 25;
    localparam int COUNT_W = 8;
    localparam int ACC_W   = R + COUNT_W;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [R-1:0]       in_data;
    logic               in_signed;
    logic [COUNT_W-1:0] len;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic               out_signed;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] exp_q[$];

    ext_accumulator #(.R(R), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_signed(in_signed), .len(len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_signed(out_signed)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]           n;
        logic [COUNT_W-1:0]   blen;
        logic                 sgn;
        logic [3:0][R-1:0]    d;
        logic [ACC_W-1:0]     exp_sum;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the sample.
    task automatic send(input logic [R-1:0] d, input logic [COUNT_W-1:0] l, input logic s);
        in_valid  = 1'b1;
        in_data   = d;
        len       = l;
        in_signed = s;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("gap_no_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    // Expect a held block sum this cycle, then pop it and check the FSM drops out_valid.
    task automatic expect_and_fire(input string name, input logic sgn);
        logic [ACC_W-1:0] e;
        e = exp_q.pop_front();
        @(negedge clk);
        chk({name, "_valid"},  64'(out_valid),  64'd1);
        chk({name, "_sum"},    64'(out_sum),    64'(e));
        chk({name, "_signed"}, 64'(out_signed), 64'(sgn));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_drop"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input int n, input int l, input logic s,
                                input logic [R-1:0] a, input logic [R-1:0] b,
                                input logic [R-1:0] c, input logic [R-1:0] d,
                                input logic [ACC_W-1:0] e);
        vec_t v;
        v.n       = 3'(n);
        v.blen    = COUNT_W'(l);
        v.sgn     = s;
        v.d       = {d, c, b, a};
        v.exp_sum = e;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(3, 3, 1'b0, 25'd1, 25'd2, 25'd3, 25'd0, 33'h6);
        vecs[1] = mk(2, 2, 1'b1, 25'h1FFFFFF, 25'h1FFFFFE, 25'd0, 25'd0, 33'h1FFFFFFFD);
        vecs[2] = mk(2, 2, 1'b0, 25'h1FFFFFF, 25'h1FFFFFE, 25'd0, 25'd0, 33'h003FFFFFD);
        vecs[3] = mk(1, 0, 1'b0, 25'd5, 25'd0, 25'd0, 25'd0, 33'h5);
        vecs[4] = mk(1, 1, 1'b1, 25'h1000000, 25'd0, 25'd0, 25'd0, 33'h1FF000000);
        vecs[5] = mk(4, 4, 1'b1, 25'h1FFFFFF, 25'd1, 25'h1FFFFFF, 25'h1FFFFFF, 33'h1FFFFFFFE);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
        len = '0; out_ready = 1'b0;
        #3;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum",   64'(out_sum),   64'd0);
        chk("rst_out_signed", 64'(out_signed), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: later samples carry inverted len/in_signed, which must be ignored.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < int'(vecs[i].n); j++)
                send(vecs[i].d[j], (j == 0) ? vecs[i].blen : ~vecs[i].blen,
                     (j == 0) ? vecs[i].sgn : ~vecs[i].sgn);
            exp_q.push_back(vecs[i].exp_sum);
            expect_and_fire($sformatf("vec%0d", i), vecs[i].sgn);
        end

        // Backpressure, then fire and a new len=1 block in the same cycle.
        send(25'h123, 8'd1, 1'b0);
        in_valid = 1'b1; in_data = 25'd7; len = 8'd1; in_signed = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid",    64'(out_valid), 64'd1);
            chk("bp_sum",      64'(out_sum),   64'h123);
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("pt_in_ready", 64'(in_ready),  64'd1);
        chk("pt_old_sum",  64'(out_sum),   64'h123);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        exp_q.push_back(33'h7);
        expect_and_fire("pt_new", 1'b0);

        // Back-to-back len=2 blocks with out_ready held high: no bubble.
        out_ready = 1'b1;
        exp_q.push_back(33'h3);
        exp_q.push_back(33'h7);
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 4);
            in_data  = 25'(c + 1);
            len      = 8'd2;
            in_signed = 1'b0;
            @(negedge clk);
            if (c < 4) chk("stream_in_ready", 64'(in_ready), 64'd1);
            if (c == 2 || c == 4) begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_sum",   64'(out_sum),   64'(exp_q.pop_front()));
            end else begin
                chk("stream_no_valid", 64'(out_valid), 64'd0);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // len=4 with two idle cycles between samples.
        for (int j = 0; j < 4; j++) begin
            send(25'(j + 1), 8'd4, 1'b0);
            if (j < 3) idle_cycles(2);
        end
        exp_q.push_back(33'd10);
        expect_and_fire("gaps", 1'b0);

        // Reset pulse mid-block discards the partial sum.
        send(25'd1, 8'd3, 1'b0);
        send(25'd2, 8'd3, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(3);
        send(25'd11, 8'd1, 1'b0);
        exp_q.push_back(33'd11);
        expect_and_fire("after_rst", 1'b0);

        // Asynchronous reset while holding a sum: outputs clear before any edge.
        send(25'd9, 8'd1, 1'b1);
        @(negedge clk);
        chk("hold_before_rst", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready",  64'(in_ready),  64'd1);
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_sum",   64'(out_sum),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(25'd4, 8'd2, 1'b0);
        send(25'd6, 8'd2, 1'b0);
        exp_q.push_back(33'd10);
        expect_and_fire("post_async", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
